// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus: request/grant handshake plus in-order response channel.
interface fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, request/grant fetch with in-order
// responses, and a small instruction buffer presenting {instr, pc} to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_unit_if.master imem,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    input  logic         stall_i,
    output logic         if_valid_o,
    output logic [31:0]  if_instr_o,
    output logic [31:0]  if_pc_o,
    output logic [31:0]  if_pc_plus4_o,
    output logic [6:0]   opcode_o
);
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CW         = AW + 1;
    localparam logic [CW:0] LIVE_LIMIT = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic [31:0]   pc_q;
    logic [31:0]   resp_pc_q;
    logic [31:0]   target_pc;
    logic [CW-1:0] count_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] drop_cnt_q;
    logic [CW-1:0] inflight_nxt;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW:0]   live;
    logic          grant;
    logic          push;
    logic          pop;

    logic [31:0] instr_mem [FIFO_DEPTH];
    logic [31:0] pc_mem    [FIFO_DEPTH];

    assign target_pc   = redirect_pc_i & 32'hFFFF_FFFC;
    assign if_valid_o  = (count_q != '0);
    assign imem.imem_addr_o = pc_q;

    always_comb begin
        // NOTE: every signal driven here is assigned unconditionally first, so no path can infer a latch.
        live             = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_cnt_q};
        imem.imem_req_o  = !rst_i && (live < LIVE_LIMIT);
        grant            = imem.imem_req_o && imem.imem_gnt_i;
        inflight_nxt     = inflight_q + CW'(grant) - CW'(imem.imem_rvalid_i);
        push             = !rst_i && !redirect_i && imem.imem_rvalid_i && (drop_cnt_q == '0);
        pop              = !rst_i && !redirect_i && if_valid_o && !stall_i;
    end

    // Buffered and in-flight words are counted together, so a flush only has to
    // remember how many stale responses are still on their way back.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst_i) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_nxt;
            if (redirect_i) begin
                pc_q       <= target_pc;
                resp_pc_q  <= target_pc;
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                drop_cnt_q <= inflight_nxt;
            end else begin
                if (grant) pc_q <= pc_q + 32'd4;
                if (imem.imem_rvalid_i && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - CW'(1);
                if (push) begin
                    wr_ptr_q  <= wr_ptr_q + AW'(1);
                    resp_pc_q <= resp_pc_q + 32'd4;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: buffer storage is not reset; if_valid_o qualifies it and the output mux hides stale words.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem.imem_rdata_i;
            pc_mem[wr_ptr_q]    <= resp_pc_q;
        end
    end

    assign if_instr_o    = if_valid_o ? instr_mem[rd_ptr_q] : NOP;
    assign if_pc_o       = if_valid_o ? pc_mem[rd_ptr_q]    : RESET_PC;
    assign if_pc_plus4_o = if_pc_o + 32'd4;
    assign opcode_o      = if_instr_o[6:0];
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: epoch-based transaction model, in-order
// memory responder with adjustable latency, and directed literal checks.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          D        = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus4_o;
    logic [6:0]  opcode_o;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(D)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem          (imem),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .if_valid_o    (if_valid_o),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_pc_plus4_o (if_pc_plus4_o),
        .opcode_o      (opcode_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h00A0_0093;
        return {a[26:0], 5'b0} | 32'h13;
    endfunction

    // Memory environment
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mem_q[$];
    int    cyc = 0;
    int    lat = 1;

    // Transaction model: each fetch is tagged with the epoch it was issued in;
    // a redirect or reset opens a new epoch and older responses are thrown away.
    typedef struct { logic [31:0] addr; int epoch; } oreq_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; logic [31:0] plus4; } pop_t;
    oreq_t       m_out[$];
    ent_t        m_fifo[$];
    pop_t        pops[$];
    logic [31:0] m_pc         = RESET_PC;
    int          m_epoch      = 0;
    bit          m_just_reset = 1'b0;

    function automatic int live_cnt();
        int n = m_fifo.size();
        foreach (m_out[i]) if (m_out[i].epoch == m_epoch) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        bit    g;
        oreq_t o;
        if (rst_i) begin
            m_pc = RESET_PC;
            m_out.delete();
            m_fifo.delete();
            m_epoch++;
            m_just_reset = 1'b1;
        end else begin
            m_just_reset = 1'b0;
            g = (live_cnt() < D) && imem.imem_gnt_i;
            if (imem.imem_rvalid_i && m_out.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_protocol: got rvalid with 0 outstanding, expected none at %0t", $time);
            end
            if (redirect_i) begin
                m_fifo.delete();
                if (imem.imem_rvalid_i && m_out.size() != 0) void'(m_out.pop_front());
                if (g) m_out.push_back('{m_pc, m_epoch});
                m_epoch++;
                m_pc = redirect_pc_i & 32'hFFFF_FFFC;
            end else begin
                if (m_fifo.size() > 0 && !stall_i) void'(m_fifo.pop_front());
                if (imem.imem_rvalid_i && m_out.size() != 0) begin
                    o = m_out.pop_front();
                    if (o.epoch == m_epoch) m_fifo.push_back('{mem_word(o.addr), o.addr});
                end
                if (g) begin
                    m_out.push_back('{m_pc, m_epoch});
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        cyc++;
        if (rst_i) mem_q.delete();
        else begin
            if (imem.imem_rvalid_i && mem_q.size() != 0) void'(mem_q.pop_front());
            if (imem.imem_req_o && imem.imem_gnt_i) mem_q.push_back('{imem.imem_addr_o, cyc + lat - 1});
        end
        #1;
        imem.imem_rvalid_i = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem.imem_rdata_i  = imem.imem_rvalid_i ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        bit er;
        er = !rst_i && (live_cnt() < D);
        check("imem_req", 32'(imem.imem_req_o), 32'(er));
        if (er) check("imem_addr", imem.imem_addr_o, m_pc);
        check("if_valid", 32'(if_valid_o), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            check("if_instr", if_instr_o, m_fifo[0].instr);
            check("if_pc", if_pc_o, m_fifo[0].pc);
            check("if_pc_plus4", if_pc_plus4_o, m_fifo[0].pc + 32'd4);
            check("opcode", 32'(opcode_o), 32'(m_fifo[0].instr[6:0]));
        end else if (m_just_reset) begin
            check("reset_instr", if_instr_o, NOP);
            check("reset_pc", if_pc_o, RESET_PC);
        end
        if (if_valid_o && !stall_i && !redirect_i && !rst_i)
            pops.push_back('{if_instr_o, if_pc_o, if_pc_plus4_o});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (if_valid_o) got = 1'b1;
            else begin
                @(posedge clk);
                #2;
            end
        end
        check({name, "_arrived"}, 32'(got), 32'd1);
        if (got) check(name, if_pc_o, exp_pc);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got no $finish by 50000, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] gnt_pat = 8'b1011_0010;
        rst_i            = 1'b1;
        redirect_i       = 1'b0;
        redirect_pc_i    = 32'h0;
        stall_i          = 1'b0;
        imem.imem_gnt_i  = 1'b1;

        // Reset for two cycles, then first request at RESET_PC
        tick(1);
        @(negedge clk);
        check("lit_reset_req", 32'(imem.imem_req_o), 32'd0);
        check("lit_reset_valid", 32'(if_valid_o), 32'd0);
        tick(1);
        rst_i = 1'b0;
        @(negedge clk);
        check("lit_first_req", 32'(imem.imem_req_o), 32'd1);
        check("lit_first_addr", imem.imem_addr_o, 32'h0);

        // Free-running stream
        tick(12);
        check("lit_pop_count", 32'(pops.size() >= 3), 32'd1);
        if (pops.size() >= 3) begin
            check("lit_pc0", pops[0].pc, 32'h0);
            check("lit_pc1", pops[1].pc, 32'h4);
            check("lit_pc2", pops[2].pc, 32'h8);
            check("lit_plus4_0", pops[0].plus4, 32'h4);
            check("lit_plus4_1", pops[1].plus4, 32'h8);
            check("lit_plus4_2", pops[2].plus4, 32'hC);
            check("lit_instr1", pops[1].instr, 32'h00A0_0093);
            check("lit_opcode0", 32'(pops[0].instr[6:0]), 32'h13);
        end

        // Withheld grants: requests must hold until accepted
        for (int i = 0; i < 8; i++) begin
            imem.imem_gnt_i = gnt_pat[i];
            tick(1);
        end
        imem.imem_gnt_i = 1'b1;
        tick(3);

        // Decode stall fills the buffer and throttles requests
        stall_i = 1'b1;
        tick(3);
        @(negedge clk);
        check("lit_stall_req", 32'(imem.imem_req_o), 32'd0);
        check("lit_stall_valid", 32'(if_valid_o), 32'd1);
        tick(2);
        stall_i = 1'b0;
        tick(6);

        // Redirect with fetches in flight
        lat = 2;
        tick(6);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        tick(1);
        redirect_i = 1'b0;
        @(negedge clk);
        check("lit_redir_addr", imem.imem_addr_o, 32'h100);
        check("lit_redir_valid", 32'(if_valid_o), 32'd0);
        wait_valid("lit_redir_pc", 32'h100);
        tick(4);

        // Misaligned redirect target while decode stalls
        lat     = 1;
        stall_i = 1'b1;
        tick(3);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        tick(1);
        redirect_i = 1'b0;
        @(negedge clk);
        check("lit_redir2_valid", 32'(if_valid_o), 32'd0);
        check("lit_redir2_addr", imem.imem_addr_o, 32'h100);
        check("lit_redir2_req", 32'(imem.imem_req_o), 32'd1);
        tick(1);
        stall_i = 1'b0;
        wait_valid("lit_redir2_pc", 32'h100);
        tick(4);

        // Reset mid-stream with work buffered and in flight
        stall_i = 1'b1;
        tick(2);
        rst_i = 1'b1;
        tick(1);
        rst_i   = 1'b0;
        stall_i = 1'b0;
        @(negedge clk);
        check("lit_rst2_valid", 32'(if_valid_o), 32'd0);
        check("lit_rst2_req", 32'(imem.imem_req_o), 32'd1);
        check("lit_rst2_addr", imem.imem_addr_o, RESET_PC);
        wait_valid("lit_rst2_pc", RESET_PC);
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
